// File: rtl/pipelined_mac_alu.sv
// pipelined_mac_alu: 2-stage ADD/MUL/MAC/CLR pipeline with ready/valid flow control; define MAC_ALU_SAT_EN for saturating MAC
module pipelined_mac_alu #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               op_sel,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [ACC_W-1:0]  result,
   output logic                     overflow
);
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_MAC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;
   logic                     en;
   logic                     s1_valid;
   logic [1:0]               s1_op;
   logic signed [ACC_W-1:0]  s1_val;
   logic signed [ACC_W-1:0]  s1_next;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  mac_val;
   logic signed [2*DATA_W-1:0] prod;
   logic                     sat;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
   // stage-1 value: sign-extended sum or full product; CLR carries zero
   always_comb begin
      s1_next = (op_sel == OP_ADD) ? ACC_W'(a) + ACC_W'(b) :
                (op_sel == OP_CLR) ? '0 : ACC_W'(prod);
   end
`ifdef MAC_ALU_SAT_EN
   logic signed [ACC_W:0] mac_sum;
   // accumulate one bit wider so a signed overflow shows as disagreeing top bits, then clamp
   always_comb begin
      mac_sum = (ACC_W+1)'(acc) + (ACC_W+1)'(s1_val);
      sat     = mac_sum[ACC_W] != mac_sum[ACC_W-1];
      mac_val = !sat ? mac_sum[ACC_W-1:0] :
                mac_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end
`else
   assign mac_val = acc + s1_val;
   assign sat     = 1'b0;
`endif
   // stage 1: capture op and operand result whenever the pipe advances
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_ADD;
         s1_val   <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         s1_op    <= op_sel;
         s1_val   <= s1_next;
      end
   end
   // stage 2: produce the result beat and update the accumulator for MAC/CLR
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         acc       <= '0;
      end else if (en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            result   <= (s1_op == OP_MAC) ? mac_val : s1_val;
            overflow <= (s1_op == OP_MAC) && sat;
            if (s1_op == OP_MAC || s1_op == OP_CLR)
               acc <= (s1_op == OP_MAC) ? mac_val : '0;
         end
      end
   end
endmodule

// File: tb/tb_pipelined_mac_alu.sv
// tb_pipelined_mac_alu: directed checks of pipelined_mac_alu with ACC_W=32
module tb_pipelined_mac_alu;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_MAC = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;
   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               in_valid = 1'b0;
   logic               out_ready = 1'b1;
   logic [1:0]         op_sel = 2'b00;
   logic signed [15:0] a = '0;
   logic signed [15:0] b = '0;
   logic               in_ready;
   logic               out_valid;
   logic               overflow;
   logic signed [31:0] result;
   int                 n_cmp = 0;
   int                 n_err = 0;

   pipelined_mac_alu #(.DATA_W(16), .ACC_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_sel(op_sel), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input int x, input int y);
      in_valid = v;
      op_sel   = op;
      a        = 16'(x);
      b        = 16'(y);
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (result !== 32'sd0) begin n_err++; $display("FAIL reset_result got %0d want 0", result); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_add;
      out_ready = 1'b1;
      drive(1'b1, OP_ADD, 100, -300);
      tick;
      drive(1'b0, OP_ADD, 0, 0);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_early got %b want 0", out_valid); end
      tick;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b want 1", out_valid); end
      n_cmp++; if (result !== -32'sd200) begin n_err++; $display("FAIL add_result got %0d want -200", result); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL add_overflow got %b want 0", overflow); end
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_bubble got %b want 0", out_valid); end
   endtask

   task automatic test_mul;
      drive(1'b1, OP_MUL, -32768, -32768);
      tick;
      drive(1'b0, OP_ADD, 0, 0);
      tick;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mul_valid got %b want 1", out_valid); end
      n_cmp++; if (result !== 32'sd1073741824) begin n_err++; $display("FAIL mul_result got %0d want 1073741824", result); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mul_overflow got %b want 0", overflow); end
      tick;
   endtask

   task automatic test_mac_seq;
      logic [1:0] ops[4] = '{OP_CLR, OP_MAC, OP_MAC, OP_CLR};
      int xs[4] = '{9, 3, 5, 9};
      int ys[4] = '{9, 4, 6, 9};
      int exp_r[4] = '{0, 12, 42, 0};
      for (int t = 0; t < 5; t++) begin
         if (t < 4) drive(1'b1, ops[t], xs[t], ys[t]);
         else drive(1'b0, OP_ADD, 0, 0);
         tick;
         if (t >= 1) begin
            n_cmp++;
            if (out_valid !== 1'b1 || result !== exp_r[t-1]) begin
               n_err++;
               $display("FAIL mac_seq beat %0d got valid=%b result=%0d want valid=1 result=%0d", t-1, out_valid, result, exp_r[t-1]);
            end
         end
      end
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mac_seq_tail got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back;
      int exp_r[4] = '{2, 4, 6, 8};
      int idx = 0;
      int oidx = 0;
      for (int c = 0; c < 12; c++) begin
         out_ready = (c >= 5);
         if (idx < 4) drive(1'b1, OP_ADD, idx + 1, idx + 1);
         else drive(1'b0, OP_ADD, 0, 0);
         @(negedge clk);
         if (out_valid) begin
            n_cmp++;
            if (oidx >= 4 || result !== exp_r[oidx < 4 ? oidx : 0]) begin
               n_err++;
               $display("FAIL b2b_result cycle %0d got %0d want beat %0d value %0d", c, result, oidx, oidx < 4 ? exp_r[oidx] : -1);
            end
         end
         if (out_valid && !out_ready) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready cycle %0d got %b want 0", c, in_ready); end
         end
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) oidx++;
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      n_cmp++;
      if (idx != 4 || oidx != 4) begin
         n_err++;
         $display("FAIL b2b_count got accepted=%0d emitted=%0d want 4/4", idx, oidx);
      end
   endtask

   task automatic test_saturation;
      logic [1:0] ops[4] = '{OP_CLR, OP_MAC, OP_MAC, OP_MAC};
`ifdef MAC_ALU_SAT_EN
      int exp_r[4] = '{0, 1073676289, 2147352578, 2147483647};
      logic exp_o[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
      int exp_r[4] = '{0, 1073676289, 2147352578, -1073938429};
      logic exp_o[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      out_ready = 1'b1;
      for (int t = 0; t < 5; t++) begin
         if (t < 4) drive(1'b1, ops[t], 32767, 32767);
         else drive(1'b0, OP_ADD, 0, 0);
         tick;
         if (t >= 1) begin
            n_cmp++;
            if (out_valid !== 1'b1 || result !== exp_r[t-1] || overflow !== exp_o[t-1]) begin
               n_err++;
               $display("FAIL sat beat %0d got valid=%b result=%0d ovf=%b want valid=1 result=%0d ovf=%b", t-1, out_valid, result, overflow, exp_r[t-1], exp_o[t-1]);
            end
         end
      end
      tick;
   endtask

   task automatic test_async_reset;
      out_ready = 1'b1;
      drive(1'b1, OP_MAC, 7, 7);
      tick;
      drive(1'b1, OP_MAC, 1, 1);
      tick;
      drive(1'b0, OP_ADD, 0, 0);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_inflight got %b want 1", out_valid); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
      n_cmp++; if (result !== 32'sd0) begin n_err++; $display("FAIL arst_result got %0d want 0", result); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL arst_overflow got %b want 0", overflow); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready got %b want 1", in_ready); end
      tick;
      rst = 1'b0;
      for (int t = 0; t < 3; t++) begin
         tick;
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_stale cycle %0d got %b want 0", t, out_valid); end
      end
      drive(1'b1, OP_MAC, 2, 3);
      tick;
      drive(1'b0, OP_ADD, 0, 0);
      tick;
      n_cmp++;
      if (out_valid !== 1'b1 || result !== 32'sd6) begin
         n_err++;
         $display("FAIL arst_acc_cleared got valid=%b result=%0d want valid=1 result=6", out_valid, result);
      end
      tick;
   endtask

   initial begin
      test_reset;
      test_add;
      test_mul;
      test_mac_seq;
      test_back_to_back;
      test_saturation;
      test_async_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
